// File: rtl/pxs_sync_gen.sv
// VGA-style sync/coordinate generator: free-running h/v counters with registered decode.
// Optional pixel clock enable via `define PXS_SYNC_CE_EN (adds the pix_ce port).
module pxs_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
`ifdef PXS_SYNC_CE_EN
  input  logic       pix_ce,
`endif
  output logic       HSync,
  output logic       VSync,
  output logic [9:0] XCoord,
  output logic [9:0] YCoord,
  output logic       ActiveVideo,
  output logic       LineStart,
  output logic       FrameStart
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Window bounds kept at 11 bits so an end bound of 1024 still compares correctly.
  localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG    = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG    = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);

  if (H_TOTAL > 1024) begin : g_h_total_err
    $error("pxs_sync_gen: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > 1024) begin : g_v_total_err
    $error("pxs_sync_gen: V_TOTAL exceeds 1024");
  end

  logic       tick;
  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic [9:0] hcnt_nxt;
  logic [9:0] vcnt_nxt;
  logic       hwrap;
  logic       vwrap;
  logic       act_dec;
  logic       hs_dec;
  logic       vs_dec;

`ifdef PXS_SYNC_CE_EN
  assign tick = pix_ce;
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    hwrap    = (hcnt == H_LAST);
    vwrap    = (vcnt == V_LAST);
    hcnt_nxt = hwrap ? 10'd0 : hcnt + 10'd1;
    vcnt_nxt = vcnt;
    if (hwrap) begin
      vcnt_nxt = vwrap ? 10'd0 : vcnt + 10'd1;
    end
  end

  always_comb begin
    act_dec = ({1'b0, hcnt} < H_ACT_END) && ({1'b0, vcnt} < V_ACT_END);
    hs_dec  = ({1'b0, hcnt} >= HS_BEG) && ({1'b0, hcnt} < HS_END);
    vs_dec  = ({1'b0, vcnt} >= VS_BEG) && ({1'b0, vcnt} < VS_END);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt <= 10'd0;
      vcnt <= 10'd0;
    end else if (tick) begin
      hcnt <= hcnt_nxt;
      vcnt <= vcnt_nxt;
    end
  end

  // Outputs are the decode of the pre-advance counters, so they trail hcnt/vcnt by one tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      HSync       <= ~SYNC_POL;
      VSync       <= ~SYNC_POL;
      XCoord      <= 10'd0;
      YCoord      <= 10'd0;
      ActiveVideo <= 1'b0;
    end else if (tick) begin
      HSync       <= hs_dec ? SYNC_POL : ~SYNC_POL;
      VSync       <= vs_dec ? SYNC_POL : ~SYNC_POL;
      XCoord      <= hcnt;
      YCoord      <= vcnt;
      ActiveVideo <= act_dec;
    end
  end

  // Markers are not held by a stalled enable: they last exactly one clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      LineStart  <= 1'b0;
      FrameStart <= 1'b0;
    end else begin
      LineStart  <= tick && (hcnt == 10'd0);
      FrameStart <= tick && (hcnt == 10'd0) && (vcnt == 10'd0);
    end
  end

endmodule
